// File: rtl/timer_pkg.sv
// Shared types and defaults for the per-level countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    EXPIRED,
    FROZEN
  } t_timer_st;

  localparam int unsigned DEF_CLK_HZ       = 31_500_000;
  localparam int unsigned DEF_LVL0_SECS    = 60;
  localparam int unsigned DEF_LVL1_SECS    = 45;
  localparam int unsigned DEF_PENALTY_SECS = 5;
  localparam int unsigned DEF_WARN_SECS    = 10;

  // Returns {tens, ones}; callers keep the value at or below 99.
  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = 31_500_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/level_countdown_timer.sv
// Level countdown timer: loads the level time, counts whole seconds down,
// applies hit penalties, and reports time-over, HUD digits and low-time warning.
module level_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = DEF_CLK_HZ,
  parameter int unsigned LVL0_SECS    = DEF_LVL0_SECS,
  parameter int unsigned LVL1_SECS    = DEF_LVL1_SECS,
  parameter int unsigned PENALTY_SECS = DEF_PENALTY_SECS,
  parameter int unsigned WARN_SECS    = DEF_WARN_SECS
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_timer,
  input  logic       lvl_indx,
  input  logic       freeze,
  input  logic       penalty,
  output logic       one_sec,
  output logic       tc,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       warn
);

  localparam logic [6:0] LVL0 = 7'(LVL0_SECS);
  localparam logic [6:0] LVL1 = 7'(LVL1_SECS);
  localparam logic [6:0] WARN = 7'(WARN_SECS);
  localparam logic [7:0] PEN  = 8'(PENALTY_SECS);

  t_timer_st  state_q;
  logic [6:0] secs_q, secs_d;
  logic       lvl_q;
  logic       one_sec_q;
  logic       tc_q;
  logic       count_en;
  logic       presc_clr;
  logic       tick;
  logic [7:0] dec;
  logic [7:0] bcd;

  // Counting happens only when no higher-priority RUN exit is taken this cycle.
  assign count_en  = (state_q == RUN) && !freeze && (lvl_indx == lvl_q) && start_timer;
  assign presc_clr = (state_q == LOAD);

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk   (clk),
    .resetN(resetN),
    .en_i  (count_en),
    .clr_i (presc_clr),
    .tick_o(tick)
  );

  always_comb begin
    dec    = {7'd0, tick} + (penalty ? PEN : 8'd0);
    secs_d = (dec >= {1'b0, secs_q}) ? '0 : secs_q - dec[6:0];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      secs_q    <= '0;
      lvl_q     <= 1'b0;
      one_sec_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      one_sec_q <= 1'b0;
      tc_q      <= (state_q == EXPIRED);
      case (state_q)
        IDLE: begin
          if (start_timer) state_q <= LOAD;
        end
        LOAD: begin
          secs_q  <= lvl_indx ? LVL1 : LVL0;
          lvl_q   <= lvl_indx;
          state_q <= RUN;
        end
        RUN: begin
          if (freeze) begin
            state_q <= FROZEN;
          end else if (lvl_indx != lvl_q) begin
            state_q <= LOAD;
          end else if (!start_timer) begin
            state_q <= IDLE;
          end else begin
            secs_q    <= secs_d;
            one_sec_q <= tick;
            if (secs_d == '0) state_q <= EXPIRED;
          end
        end
        EXPIRED, FROZEN: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd       = bin2bcd(secs_q);
  assign secs_tens = bcd[7:4];
  assign secs_ones = bcd[3:0];
  assign one_sec   = one_sec_q;
  assign tc        = tc_q;
  assign warn      = (state_q == RUN) && (secs_q != '0) && (secs_q <= WARN);

endmodule
